// File: rtl/pipe_pkg.sv
// Shared opcodes and sequencer state encoding for the
// pipeline control / LM-SM micro-op sequencer.
package pipe_pkg;

   localparam logic [3:0] OP_LW = 4'b0100;
   localparam logic [3:0] OP_LM = 4'b0110;
   localparam logic [3:0] OP_SM = 4'b0111;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_LU_STALL = 2'd1,
      S_SEQ      = 2'd2
   } state_e;

   function automatic logic is_multi(input logic [3:0] op);
      return (op == OP_LM) || (op == OP_SM);
   endfunction

endpackage

// File: rtl/prio_enc.sv
// Lowest-set-bit priority encoder: index of the lowest
// set bit of vec, vld=0 when vec is all zeros.
module prio_enc #(
   parameter int NUM_REGS = 8,
   parameter int RA_W     = $clog2(NUM_REGS)
) (
   input  logic [NUM_REGS-1:0] vec,
   output logic [RA_W-1:0]     idx,
   output logic                vld
);

   always_comb begin
      idx = '0;
      vld = 1'b0;
      for (int i = NUM_REGS - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = RA_W'(i);
            vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pipe_ctrl_seq.sv
// Hazard/flush control with LM/SM micro-op sequencer.
// All outputs are registered alongside the FSM state.
module pipe_ctrl_seq
   import pipe_pkg::*;
#(
   parameter int NUM_REGS = 8,
   parameter int RA_W     = $clog2(NUM_REGS),
   parameter int OFS_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                id_valid,
   input  logic [3:0]          id_opcode,
   input  logic [NUM_REGS-1:0] id_rlist,
   input  logic [RA_W-1:0]     id_rs1,
   input  logic [RA_W-1:0]     id_rs2,
   input  logic [1:0]          id_rs_used,
   input  logic                ex_is_load,
   input  logic [RA_W-1:0]     ex_rd,
   input  logic                ex_flush,
   output logic                stall_if,
   output logic                flush_id,
   output logic                uop_valid,
   output logic [RA_W-1:0]     uop_reg,
   output logic [OFS_W-1:0]    uop_ofs,
   output logic                uop_mem_we,
   output logic                uop_rf_we,
   output logic                seq_busy
);

   state_e              state_q, state_d;
   logic [NUM_REGS-1:0] mask_q, mask_d;
   logic [OFS_W-1:0]    cnt_q, cnt_d;
   logic                is_sm_q, is_sm_d;

   logic                stall_if_d, flush_id_d, uop_valid_d;
   logic [RA_W-1:0]     uop_reg_d;
   logic [OFS_W-1:0]    uop_ofs_d;
   logic                uop_mem_we_d, uop_rf_we_d, seq_busy_d;

   logic [NUM_REGS-1:0] sel_vec;
   logic [RA_W-1:0]     pe_idx;
   logic                pe_vld;
   logic                hazard;
   logic                issue;

   // In SEQ the encoder walks the pending mask, otherwise it
   // looks ahead at the incoming register list.
   assign sel_vec = (state_q == S_SEQ) ? mask_q : id_rlist;

   prio_enc #(
      .NUM_REGS(NUM_REGS),
      .RA_W    (RA_W)
   ) u_prio_enc (
      .vec(sel_vec),
      .idx(pe_idx),
      .vld(pe_vld)
   );

   assign hazard = ex_is_load &&
      ((id_rs_used[0] && (ex_rd == id_rs1)) ||
       (id_rs_used[1] && (ex_rd == id_rs2)));

   always_comb begin
      state_d      = state_q;
      mask_d       = mask_q;
      cnt_d        = cnt_q;
      is_sm_d      = is_sm_q;
      stall_if_d   = 1'b0;
      flush_id_d   = 1'b0;
      uop_valid_d  = 1'b0;
      uop_reg_d    = '0;
      uop_ofs_d    = '0;
      uop_mem_we_d = 1'b0;
      uop_rf_we_d  = 1'b0;
      issue        = 1'b0;

      if (ex_flush) begin
         state_d    = S_IDLE;
         mask_d     = '0;
         cnt_d      = '0;
         flush_id_d = 1'b1;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               mask_d = '0;
               cnt_d  = '0;
               if (id_valid && hazard) begin
                  state_d    = S_LU_STALL;
                  stall_if_d = 1'b1;
                  flush_id_d = 1'b1;
               end else if (id_valid && is_multi(id_opcode) && pe_vld) begin
                  state_d = S_SEQ;
                  mask_d  = id_rlist;
                  is_sm_d = (id_opcode == OP_SM);
                  issue   = 1'b1;
               end
            end
            S_LU_STALL: state_d = S_IDLE;
            S_SEQ: begin
               if (pe_vld) issue = 1'b1;
               else        state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end

      // Stall is held until the final micro-op is on the way out.
      if (issue) begin
         mask_d       = mask_d & ~(NUM_REGS'(1) << pe_idx);
         uop_valid_d  = 1'b1;
         uop_reg_d    = pe_idx;
         uop_ofs_d    = cnt_d;
         cnt_d        = cnt_d + OFS_W'(1);
         uop_mem_we_d = is_sm_d;
         uop_rf_we_d  = !is_sm_d;
         stall_if_d   = |mask_d;
      end

      seq_busy_d = (state_d == S_SEQ);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         mask_q     <= '0;
         cnt_q      <= '0;
         is_sm_q    <= 1'b0;
         stall_if   <= 1'b0;
         flush_id   <= 1'b0;
         uop_valid  <= 1'b0;
         uop_reg    <= '0;
         uop_ofs    <= '0;
         uop_mem_we <= 1'b0;
         uop_rf_we  <= 1'b0;
         seq_busy   <= 1'b0;
      end else begin
         state_q    <= state_d;
         mask_q     <= mask_d;
         cnt_q      <= cnt_d;
         is_sm_q    <= is_sm_d;
         stall_if   <= stall_if_d;
         flush_id   <= flush_id_d;
         uop_valid  <= uop_valid_d;
         uop_reg    <= uop_reg_d;
         uop_ofs    <= uop_ofs_d;
         uop_mem_we <= uop_mem_we_d;
         uop_rf_we  <= uop_rf_we_d;
         seq_busy   <= seq_busy_d;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl_seq.sv
// Scoreboard bench for pipe_ctrl_seq: a queue-based reference
// model predicts each cycle's outputs, a monitor compares them.
module tb_pipe_ctrl_seq;

   localparam int N     = 16;
   localparam int RW    = 4;
   localparam int OW    = 16;
   localparam logic [3:0] LM = 4'b0110;
   localparam logic [3:0] SM = 4'b0111;

   logic          clk = 1'b0;
   logic          rst;
   logic          id_valid;
   logic [3:0]    id_opcode;
   logic [N-1:0]  id_rlist;
   logic [RW-1:0] id_rs1, id_rs2;
   logic [1:0]    id_rs_used;
   logic          ex_is_load;
   logic [RW-1:0] ex_rd;
   logic          ex_flush;
   logic          stall_if, flush_id, uop_valid;
   logic [RW-1:0] uop_reg;
   logic [OW-1:0] uop_ofs;
   logic          uop_mem_we, uop_rf_we, seq_busy;

   typedef struct packed {
      logic          stall;
      logic          flush;
      logic          uv;
      logic [RW-1:0] rg;
      logic [OW-1:0] ofs;
      logic          mwe;
      logic          rwe;
      logic          busy;
   } exp_t;

   exp_t expq[$];
   int   vectors = 0;
   int   errors  = 0;
   int   cyc     = 0;

   // Reference model state: 0 idle, 1 load-use bubble, 2 sequencing
   int   mode = 0;
   int   pend[$];
   int   ofs  = 0;
   bit   sm   = 1'b0;

   always #5 clk = ~clk;

   pipe_ctrl_seq #(.NUM_REGS(N), .RA_W(RW), .OFS_W(OW)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rlist(id_rlist), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs_used(id_rs_used), .ex_is_load(ex_is_load),
      .ex_rd(ex_rd), .ex_flush(ex_flush),
      .stall_if(stall_if), .flush_id(flush_id),
      .uop_valid(uop_valid), .uop_reg(uop_reg),
      .uop_ofs(uop_ofs), .uop_mem_we(uop_mem_we),
      .uop_rf_we(uop_rf_we), .seq_busy(seq_busy)
   );

   task automatic model_push();
      exp_t e;
      bit   issue;
      bit   hz;
      e     = '0;
      issue = 1'b0;
      hz = ex_is_load &&
           ((id_rs_used[0] && ex_rd == id_rs1) ||
            (id_rs_used[1] && ex_rd == id_rs2));
      if (rst) begin
         mode = 0;
         pend.delete();
      end else if (ex_flush) begin
         mode = 0;
         pend.delete();
         e.flush = 1'b1;
      end else if (mode == 1) begin
         mode = 0;
      end else if (mode == 2) begin
         if (pend.size() == 0) mode = 0;
         else issue = 1'b1;
      end else if (id_valid && hz) begin
         mode    = 1;
         e.stall = 1'b1;
         e.flush = 1'b1;
      end else if (id_valid && (id_opcode == LM || id_opcode == SM)
                   && id_rlist != '0) begin
         pend.delete();
         for (int i = 0; i < N; i++)
            if (id_rlist[i]) pend.push_back(i);
         ofs   = 0;
         sm    = (id_opcode == SM);
         mode  = 2;
         issue = 1'b1;
      end
      if (issue) begin
         e.uv    = 1'b1;
         e.rg    = RW'(pend.pop_front());
         e.ofs   = OW'(ofs);
         ofs     = ofs + 1;
         e.mwe   = sm;
         e.rwe   = !sm;
         e.stall = (pend.size() != 0);
         e.busy  = 1'b1;
      end
      expq.push_back(e);
   endtask

   task automatic tick();
      model_push();
      @(posedge clk);
      #2;
      cyc++;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic quiet();
      rst        = 1'b0;
      id_valid   = 1'b0;
      id_opcode  = 4'b0000;
      id_rlist   = '0;
      id_rs1     = 4'd1;
      id_rs2     = 4'd2;
      id_rs_used = 2'b00;
      ex_is_load = 1'b0;
      ex_rd      = 4'd0;
      ex_flush   = 1'b0;
   endtask

   task automatic instr(input logic [3:0] op, input logic [N-1:0] rl);
      id_valid  = 1'b1;
      id_opcode = op;
      id_rlist  = rl;
   endtask

   always @(negedge clk) begin
      exp_t e, g;
      if (expq.size() > 0) begin
         e = expq.pop_front();
         g = {stall_if, flush_id, uop_valid, uop_reg, uop_ofs,
              uop_mem_we, uop_rf_we, seq_busy};
         vectors++;
         if (g !== e) begin
            errors++;
            $display("FAIL outputs cyc=%0d got st=%b fl=%b v=%b r=%0d o=%0d mw=%b rw=%b b=%b exp st=%b fl=%b v=%b r=%0d o=%0d mw=%b rw=%b b=%b",
               cyc, g.stall, g.flush, g.uv, g.rg, g.ofs, g.mwe, g.rwe, g.busy,
               e.stall, e.flush, e.uv, e.rg, e.ofs, e.mwe, e.rwe, e.busy);
         end
      end
   end

   initial begin
      quiet();
      #1;
      rst = 1'b1;
      ticks(2);
      rst = 1'b0;
      ticks(1);

      // LM with a sparse list
      instr(LM, 16'h00A5);
      ticks(4);
      quiet();
      ticks(2);

      // SM with an empty list is a plain NOP
      instr(SM, 16'h0000);
      ticks(2);
      quiet();
      ticks(1);

      // load-use on rs2
      instr(4'b0001, '0);
      ex_is_load = 1'b1; ex_rd = 4'd3;
      id_rs1 = 4'd5; id_rs2 = 4'd3; id_rs_used = 2'b10;
      ticks(1);
      ex_is_load = 1'b0;
      ticks(2);
      // matching rs2 but not used: no hazard
      ex_is_load = 1'b1; id_rs_used = 2'b01;
      ticks(2);
      // hazard has priority over an LM start
      id_rs_used = 2'b10;
      instr(LM, 16'h0003);
      ticks(1);
      ex_is_load = 1'b0;
      ticks(4);
      quiet();
      ticks(1);

      // SM full list, flushed after two micro-ops
      instr(SM, 16'h00FF);
      ticks(2);
      ex_flush = 1'b1;
      ticks(1);
      quiet();
      ticks(3);

      // reset in the middle of a sequence
      instr(LM, 16'h00F0);
      ticks(2);
      rst = 1'b1;
      ticks(1);
      quiet();
      ticks(3);

      // extreme bits of a 16-entry list
      instr(LM, 16'h8001);
      ticks(2);
      quiet();
      ticks(2);

      // flush during the load-use bubble
      instr(4'b0010, '0);
      ex_is_load = 1'b1; ex_rd = 4'd1; id_rs_used = 2'b01;
      ticks(1);
      quiet();
      ex_flush = 1'b1;
      ticks(1);
      quiet();
      ticks(2);

      for (int k = 0; k < 3000; k++) begin
         int sel;
         rst        = ($urandom_range(0, 199) == 0);
         ex_flush   = ($urandom_range(0, 39) == 0);
         id_valid   = ($urandom_range(0, 9) < 8);
         sel        = $urandom_range(0, 3);
         id_opcode  = (sel == 0) ? LM : (sel == 1) ? SM :
                      4'($urandom_range(0, 15));
         id_rlist   = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
         id_rs1     = RW'($urandom_range(0, 3));
         id_rs2     = RW'($urandom_range(0, 3));
         id_rs_used = 2'($urandom_range(0, 3));
         ex_is_load = ($urandom_range(0, 3) == 0);
         ex_rd      = RW'($urandom_range(0, 3));
         tick();
      end

      quiet();
      ticks(N + 2);
      #5;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending required 0", expq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, errors);
      $finish;
   end

endmodule
